// File: rtl/uart_cmd_rx_if.sv
// uart_cmd_rx_if: command-word handshake between receiver and acquisition control
//   word_data  : received word {byte0, byte1}
//   word_valid : word_data holds an unconsumed word
//   word_ready : consumer accepts the word this cycle
interface uart_cmd_rx_if;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready;
  modport master (output word_data, word_valid, input word_ready);
  modport slave  (input word_data, word_valid, output word_ready);
endinterface

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 receiver pairing bytes into 16-bit command words, high byte first
//   clk, reset_n                : clock, asynchronous active-low reset
//   rx                          : asynchronous serial input, idle high
//   word                        : master side of the word_data/word_valid/word_ready holding register
//   frame_err, overrun, timeout : one-cycle event pulses
//   busy                        : receiving a byte or holding the first byte of a word
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx,
  uart_cmd_rx_if.master word,
  output logic          frame_err,
  output logic          overrun,
  output logic          timeout,
  output logic          busy
);
  localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] TLIM = CW'(TMO);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  state_t        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, tcnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q, hi_q;
  logic [15:0]   data_q;
  logic          flag_q, valid_q, frame_err_q, overrun_q, timeout_q;
  logic          rx_s, start_d, sample_d, load_d;
  assign rx_s     = sync_q[1];
  assign start_d  = state_q == IDLE && !rx_s;
  // cnt_q holds cycles since START entry (first sample at half a bit) or since the previous sample
  assign sample_d = cnt_q == (state_q == START ? HALF : FULL);
  assign load_d   = !valid_q || word.word_ready;
  assign word.word_data  = data_q;
  assign word.word_valid = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;
  assign busy      = state_q != IDLE || flag_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      hi_q        <= '0;
      data_q      <= '0;
      flag_q      <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      cnt_q       <= (state_q inside {IDLE, WAIT_HI} || sample_d) ? ONE : cnt_q + ONE;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      if (valid_q && word.word_ready) valid_q <= 1'b0;
      // timer restarts at each START entry so only the idle gap before a byte can expire it
      if (flag_q) begin
        if (start_d) tcnt_q <= '0;
        else if (tcnt_q == TLIM) begin
          timeout_q <= 1'b1;
          flag_q    <= 1'b0;
        end else tcnt_q <= tcnt_q + ONE;
      end
      case (state_q)
        IDLE: if (!rx_s) state_q <= START;
        START: if (sample_d) begin
          state_q <= rx_s ? IDLE : DATA;
          bit_q   <= '0;
        end
        DATA: if (sample_d) begin
          sh_q  <= {rx_s, sh_q[7:1]};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= STOP;
        end
        STOP: if (sample_d) begin
          if (!rx_s) begin
            frame_err_q <= 1'b1;
            flag_q      <= 1'b0;
            state_q     <= WAIT_HI;
          end else begin
            state_q <= IDLE;
            flag_q  <= !flag_q;
            if (!flag_q) begin
              hi_q   <= sh_q;
              tcnt_q <= ONE;
            end else if (load_d) begin
              data_q  <= {hi_q, sh_q};
              valid_q <= 1'b1;
            end else overrun_q <= 1'b1;
          end
        end
        WAIT_HI: if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed and randomized bench for uart_cmd_rx against a byte-pairing reference model
module tb_uart_cmd_rx;
  localparam int CPB = 16;
  localparam int TB = 24;
  localparam int BYTE_T = 10 * CPB;
  // rx drive to stop-sample cycle: 2 synchroniser cycles, half a bit, nine bits
  localparam int STOP_SMP = 2 + CPB / 2 + 9 * CPB;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  logic frame_err, overrun, timeout, busy;
  uart_cmd_rx_if wif();
  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .word(wif),
    .frame_err(frame_err), .overrun(overrun), .timeout(timeout), .busy(busy)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  int cyc = 0, rise_cyc = 0, fe_n = 0, ov_n = 0, to_n = 0, vh_n = 0;
  int c0, g0, fe0, ov0, to0, vh0;
  logic v_prev = 1'b0;
  logic [15:0] got[$];
  bit rand_rdy = 1'b0;
  always @(negedge clk) begin
    if (wif.word_valid && wif.word_ready) got.push_back(wif.word_data);
    if (frame_err) fe_n++;
    if (overrun) ov_n++;
    if (timeout) to_n++;
    if (wif.word_valid && !v_prev) rise_cyc = cyc;
    v_prev = wif.word_valid;
    vh_n += int'(wif.word_valid);
    cyc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    c0 = cyc; g0 = got.size(); fe0 = fe_n; ov0 = ov_n; to0 = to_n; vh0 = vh_n;
  endtask
  function automatic logic [15:0] last_got();
    return got.size() > 0 ? got[got.size()-1] : 16'hxxxx;
  endfunction
  task automatic drive_rdy();
    if (rand_rdy) wif.word_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stopv, input bit pulse, input int abort);
    for (int i = 0; i < BYTE_T; i++) begin
      if (i == abort) return;
      rx = (i < CPB) ? 1'b0 : (i < 9 * CPB) ? b[3'((i - CPB) / CPB)] : stopv;
      drive_rdy();
      if (pulse) wif.word_ready = (i == STOP_SMP);
      tick();
    end
  endtask
  task automatic idle(input int nbits);
    for (int i = 0; i < nbits * CPB; i++) begin
      rx = 1'b1;
      drive_rdy();
      tick();
    end
  endtask
  initial begin
    logic [15:0] exp_q[$];
    logic [7:0] held, b;
    bit held_v, bad;
    int fe_exp;
    wif.word_ready = 1'b0;
    repeat (3) tick();
    chk("rst_data", wif.word_data, 0);
    chk("rst_valid", wif.word_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    wif.word_ready = 1'b1;
    snap();
    send_byte(8'h12, 1'b1, 1'b0, -1);
    send_byte(8'h34, 1'b1, 1'b0, -1);
    chk("w1234_latency", rise_cyc - c0, BYTE_T + STOP_SMP + 1);
    chk("w1234_count", got.size() - g0, 1);
    chk("w1234_data", last_got(), 16'h1234);
    chk("w1234_valid_cycles", vh_n - vh0, 1);
    chk("w1234_flags", (fe_n - fe0) + (ov_n - ov0) + (to_n - to0), 0);
    snap();
    rx = 1'b0;
    repeat (5) tick();
    chk("glitch_busy_start", busy, 1);
    rx = 1'b1;
    repeat (9) tick();
    chk("glitch_busy_idle", busy, 0);
    idle(2);
    chk("glitch_flags", (fe_n - fe0) + (ov_n - ov0) + (to_n - to0), 0);
    chk("glitch_words", got.size() - g0, 0);
    snap();
    send_byte(8'hAB, 1'b0, 1'b0, -1);
    idle(1);
    send_byte(8'h55, 1'b1, 1'b0, -1);
    send_byte(8'h66, 1'b1, 1'b0, -1);
    idle(1);
    chk("frame_err_pulses", fe_n - fe0, 1);
    chk("frame_words", got.size() - g0, 1);
    chk("frame_data", last_got(), 16'h5566);
    wif.word_ready = 1'b0;
    snap();
    send_byte(8'h01, 1'b1, 1'b0, -1);
    send_byte(8'h02, 1'b1, 1'b0, -1);
    send_byte(8'h03, 1'b1, 1'b0, -1);
    send_byte(8'h04, 1'b1, 1'b0, -1);
    chk("ovr_pulses", ov_n - ov0, 1);
    chk("ovr_data_kept", wif.word_data, 16'h0102);
    chk("ovr_valid", wif.word_valid, 1);
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    chk("ovr_drain_data", last_got(), 16'h0102);
    chk("ovr_drain_valid", wif.word_valid, 0);
    snap();
    send_byte(8'h01, 1'b1, 1'b0, -1);
    send_byte(8'h02, 1'b1, 1'b0, -1);
    send_byte(8'h03, 1'b1, 1'b0, -1);
    send_byte(8'h04, 1'b1, 1'b1, -1);
    chk("swap_no_overrun", ov_n - ov0, 0);
    chk("swap_consumed", last_got(), 16'h0102);
    chk("swap_data", wif.word_data, 16'h0304);
    chk("swap_valid", wif.word_valid, 1);
    wif.word_ready = 1'b1;
    tick();
    chk("swap_drain", last_got(), 16'h0304);
    snap();
    send_byte(8'h77, 1'b1, 1'b0, -1);
    idle(TB);
    send_byte(8'h88, 1'b1, 1'b0, -1);
    send_byte(8'h99, 1'b1, 1'b0, -1);
    idle(1);
    chk("tmo_pulses", to_n - to0, 1);
    chk("tmo_words", got.size() - g0, 1);
    chk("tmo_data", last_got(), 16'h8899);
    snap();
    send_byte(8'h21, 1'b1, 1'b0, -1);
    idle(TB - 1);
    send_byte(8'h43, 1'b1, 1'b0, -1);
    idle(1);
    chk("notmo_pulses", to_n - to0, 0);
    chk("notmo_data", last_got(), 16'h2143);
    wif.word_ready = 1'b0;
    send_byte(8'h5A, 1'b1, 1'b0, -1);
    send_byte(8'hA5, 1'b1, 1'b0, -1);
    send_byte(8'h12, 1'b1, 1'b0, -1);
    send_byte(8'h34, 1'b1, 1'b0, 2 + CPB / 2 + 5 * CPB - 2);
    chk("pre_rst_valid", wif.word_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", wif.word_valid, 0);
    chk("arst_data", wif.word_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_flags", {frame_err, overrun, timeout}, 0);
    rx = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    wif.word_ready = 1'b1;
    snap();
    send_byte(8'hCA, 1'b1, 1'b0, -1);
    send_byte(8'hFE, 1'b1, 1'b0, -1);
    idle(1);
    chk("cafe_words", got.size() - g0, 1);
    chk("cafe_data", last_got(), 16'hCAFE);
    snap();
    held_v = 1'b0;
    fe_exp = 0;
    rand_rdy = 1'b1;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      bad = $urandom_range(0, 5) == 0;
      send_byte(b, !bad, 1'b0, -1);
      idle($urandom_range(1, 4));
      if (bad) begin
        fe_exp++;
        held_v = 1'b0;
      end else if (!held_v) begin
        held = b;
        held_v = 1'b1;
      end else begin
        exp_q.push_back({held, b});
        held_v = 1'b0;
      end
    end
    idle(TB + 2);
    rand_rdy = 1'b0;
    wif.word_ready = 1'b1;
    repeat (3) tick();
    chk("rand_frame_err", fe_n - fe0, fe_exp);
    chk("rand_timeout", to_n - to0, int'(held_v));
    chk("rand_overrun", ov_n - ov0, 0);
    chk("rand_words", got.size() - g0, exp_q.size());
    foreach (exp_q[j]) chk("rand_word", (g0 + j < got.size()) ? got[g0+j] : 16'hxxxx, exp_q[j]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
